mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single data-memory port between two requesters (REQ 0 = data-cache path, REQ 1 = instruction-fetch path).
//  Picks one requester per transaction (round-robin on contention) and drives SELECT to the external mux8/mux32 that steer address/data.
//  Forwards READ/WRITE to memory, holds the grant until memory completes, then releases the requester via its BUSYWAIT.
// PARAMETERS
//  TIMEOUT_CYCLES  64  max cycles in BUSY before abort (used only with ARB_TIMEOUT_EN)
//  CNT_W           8   width of timeout counter; must satisfy 2**CNT_W > TIMEOUT_CYCLES
// PORTS
//  CLK           in   1  clock, all state updates on posedge
//  RESET         in   1  asynchronous, active-high reset
//  READ0/WRITE0  in   1  requester 0 read/write request, held until BUSYWAIT0 low
//  READ1/WRITE1  in   1  requester 1 read/write request, held until BUSYWAIT1 low
//  BUSYWAIT0     out  1  stall to requester 0
//  BUSYWAIT1     out  1  stall to requester 1
//  SELECT        out  1  mux select: 0 = requester 0 path, 1 = requester 1 path
//  MEM_READ      out  1  read strobe to memory
//  MEM_WRITE     out  1  write strobe to memory
//  MEM_BUSYWAIT  in   1  memory busy; registered inside memory
//  ARB_ERROR     out  1  one-cycle pulse on timeout abort (tied 0 without ARB_TIMEOUT_EN)
// BEHAVIOUR
//  - Reset (async, immediate): state=IDLE, SELECT=0, MEM_READ=MEM_WRITE=0, ARB_ERROR=0, LAST=1 (req0 wins first contention), counter=0.
//  - REQi = READi|WRITEi. If READi&WRITEi, only the read is forwarded.
//  - BUSYWAITi (combinational) = REQi & !(state==DONE & SELECT==i). During reset it equals REQi.
//  - IDLE: MEM_READ/WRITE=0, SELECT holds last value. On posedge with any REQ: grant the sole requester, or on contention the one !=LAST;
//    register SELECT=grant, MEM_READ/MEM_WRITE from granted requester's READ/WRITE; -> BUSY. No request: stay.
//  - BUSY: strobes and SELECT stable. First BUSY cycle ignores MEM_BUSYWAIT (memory needs one cycle to raise it).
//    From second cycle on: MEM_BUSYWAIT sampled 0 -> DONE, strobes cleared on that edge.
//  - DONE (exactly 1 cycle): BUSYWAIT of granted requester low; LAST<=SELECT; -> IDLE. Requester must drop REQ this cycle.
//  - Grant-to-memory latency: 1 cycle from REQ seen in IDLE. Minimum transaction: IDLE->BUSY(2)->DONE = 4 cycles.
//  - Requester dropping REQ while granted: ignored, transaction completes; no new grant until IDLE.
//  - New request arriving during BUSY/DONE from the other requester: waits (BUSYWAIT high), considered in next IDLE.
//  - Back-to-back contention alternates grants strictly (0,1,0,1...).
//  - RESET mid-transaction: strobes drop immediately; in-flight memory op abandoned.
// CONFIGURATION
//  ARB_TIMEOUT_EN defined: counter cleared on entering BUSY, +1 per BUSY cycle; reaching TIMEOUT_CYCLES forces BUSY->DONE,
//    strobes cleared, ARB_ERROR=1 for the DONE cycle; requester is released normally (data invalid).
//  ARB_TIMEOUT_EN undefined: no counter logic; BUSY waits indefinitely; ARB_ERROR constant 0 (port kept).
// STRUCTURE
//  Shared package arb_pkg: state codes ARB_IDLE=2'b00, ARB_BUSY=2'b01, ARB_DONE=2'b10; requester IDs REQ_DCACHE=1'b0, REQ_IFETCH=1'b1.
//  One sub-module: arb_rr_picker (combinational: REQ0, REQ1, LAST -> GRANT, VALID); FSM, strobes, counter in top.
// TESTING
//  1. Reset with READ0=1 -> BUSYWAIT0=1, MEM_READ=0, SELECT=0; release reset -> next edge MEM_READ=1, SELECT=0.
//  2. WRITE1 alone, memory busy 3 cycles -> SELECT=1, MEM_WRITE high until busy low, BUSYWAIT1 low in DONE only, 6-cycle txn.
//  3. READ0 and READ1 held together for 4 txns -> grants 0,1,0,1; the waiting requester's BUSYWAIT stays high throughout.
//  4. RESET pulse mid-BUSY -> MEM_READ/MEM_WRITE drop same cycle, state IDLE, LAST=1, next contention grants req0.
//  5. ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, MEM_BUSYWAIT stuck 1 -> abort after 8 BUSY cycles, ARB_ERROR 1-cycle pulse, requester released.
//  6. READ0&WRITE0 both high -> only MEM_READ asserted, MEM_WRITE stays 0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types for the data-memory port arbiter: FSM state codes and requester IDs.
// No logic, no latency.
// Backpressure is not applicable here.
package arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_BUSY = 2'b01,
        ARB_DONE = 2'b10
    } arb_state_t;

    localparam logic REQ_DCACHE = 1'b0;
    localparam logic REQ_IFETCH = 1'b1;

endpackage

// File: rtl/arb_rr_picker.sv
// Round-robin choice between the two requesters; on contention the one that did not win last.
// Combinational, zero latency.
// No backpressure; the caller decides when the pick is taken.
module arb_rr_picker
    import arb_pkg::*;
(
    input  logic REQ0,
    input  logic REQ1,
    input  logic LAST,
    output logic GRANT,
    output logic VALID
);

    always_comb begin
        VALID = REQ0 | REQ1;
        if (REQ0 && REQ1) begin
            GRANT = ~LAST;
        end else if (REQ1) begin
            GRANT = REQ_IFETCH;
        end else begin
            GRANT = REQ_DCACHE;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one data-memory port between dcache (0) and ifetch (1); optional abort via ARB_TIMEOUT_EN.
// Strobes one cycle after a request is seen in IDLE; min transaction IDLE->BUSY(2)->DONE = 4 cycles.
// Requesters stall on BUSYWAITi until their DONE cycle; losers simply wait for the next IDLE.
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 8
) (
    input  logic CLK,
    input  logic RESET,
    input  logic READ0,
    input  logic WRITE0,
    input  logic READ1,
    input  logic WRITE1,
    output logic BUSYWAIT0,
    output logic BUSYWAIT1,
    output logic SELECT,
    output logic MEM_READ,
    output logic MEM_WRITE,
    input  logic MEM_BUSYWAIT,
    output logic ARB_ERROR
);

    if (2 ** CNT_W <= TIMEOUT_CYCLES) begin : g_bad_cnt_w
        $error("CNT_W too narrow for TIMEOUT_CYCLES");
    end

    arb_state_t state_q, state_d;
    logic       select_q, select_d;
    logic       mem_read_q, mem_read_d;
    logic       mem_write_q, mem_write_d;
    logic       last_q, last_d;
    logic       first_q, first_d;
    logic       req0, req1, grant, grant_vld;
    logic       grant_rd, grant_wr;

`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             arb_error_q, arb_error_d;
`endif

    assign req0 = READ0 | WRITE0;
    assign req1 = READ1 | WRITE1;

    arb_rr_picker u_picker (
        .REQ0  (req0),
        .REQ1  (req1),
        .LAST  (last_q),
        .GRANT (grant),
        .VALID (grant_vld)
    );

    // A simultaneous read+write from one requester forwards only the read.
    assign grant_rd = grant ? READ1 : READ0;
    assign grant_wr = (grant ? WRITE1 : WRITE0) & ~grant_rd;

    always_comb begin
        state_d     = state_q;
        select_d    = select_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        last_d      = last_q;
        first_d     = 1'b0;
`ifdef ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
        arb_error_d = 1'b0;
`endif
        case (state_q)
            ARB_IDLE: begin
                if (grant_vld) begin
                    state_d     = ARB_BUSY;
                    select_d    = grant;
                    mem_read_d  = grant_rd;
                    mem_write_d = grant_wr;
                    first_d     = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                end
            end
            ARB_BUSY: begin
`ifdef ARB_TIMEOUT_EN
                cnt_d = cnt_q + 1'b1;
`endif
                // Memory registers its busy flag, so the first BUSY cycle's value is stale.
                if (!first_q && !MEM_BUSYWAIT) begin
                    state_d     = ARB_DONE;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                end
`ifdef ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d     = ARB_DONE;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    arb_error_d = 1'b1;
                end
`endif
            end
            ARB_DONE: begin
                last_d  = select_q;
                state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= ARB_IDLE;
            select_q    <= REQ_DCACHE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            last_q      <= REQ_IFETCH;
            first_q     <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            cnt_q       <= '0;
            arb_error_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            select_q    <= select_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            last_q      <= last_d;
            first_q     <= first_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q       <= cnt_d;
            arb_error_q <= arb_error_d;
`endif
        end
    end

    assign BUSYWAIT0 = req0 & ~((state_q == ARB_DONE) & (select_q == REQ_DCACHE));
    assign BUSYWAIT1 = req1 & ~((state_q == ARB_DONE) & (select_q == REQ_IFETCH));
    assign SELECT    = select_q;
    assign MEM_READ  = mem_read_q;
    assign MEM_WRITE = mem_write_q;
`ifdef ARB_TIMEOUT_EN
    assign ARB_ERROR = arb_error_q;
`else
    assign ARB_ERROR = 1'b0;
`endif

endmodule
